// File: rtl/amo_executor_pkg.sv
// Shared types for the AMO executor: request/response structs, op encoding,
// FSM state enum and the lane-steering helpers used by the executor and its ALU.
package amo_executor_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'b0000,
    AMO_LR   = 4'b0001,
    AMO_SC   = 4'b0010,
    AMO_SWAP = 4'b0011,
    AMO_ADD  = 4'b0100,
    AMO_AND  = 4'b0101,
    AMO_OR   = 4'b0110,
    AMO_XOR  = 4'b0111,
    AMO_MAX  = 4'b1000,
    AMO_MAXU = 4'b1001,
    AMO_MIN  = 4'b1010,
    AMO_MINU = 4'b1011,
    AMO_CAS1 = 4'b1100,
    AMO_CAS2 = 4'b1101
  } amo_t;

  typedef struct packed {
    logic        req;
    amo_t        amo_op;
    logic [1:0]  size;
    logic [63:0] operand_a;
    logic [63:0] operand_b;
  } amo_req_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RESP    = 3'd4
  } amo_exec_state_e;

  localparam logic [63:0] AMO_SC_FAIL = 64'd1;
  localparam logic [1:0]  SIZE_W      = 2'b10;

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Word data goes out on both halves; byte enables pick the real one.
  function automatic logic [63:0] lane_wdata(input logic is_word, input logic [63:0] v);
    return is_word ? {v[31:0], v[31:0]} : v;
  endfunction

  function automatic logic [7:0] lane_be(input logic is_word, input logic hi);
    if (is_word) begin
      return hi ? 8'hF0 : 8'h0F;
    end else begin
      return 8'hFF;
    end
  endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO ALU: (op, size, old value a, operand b) -> value to store.
// Word operands are sign-extended first so signed and unsigned compares both follow the ISA.
module amo_alu
  import amo_executor_pkg::*;
(
  input  amo_t        op,
  input  logic        is_word,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result
);

  logic [63:0] a_s;
  logic [63:0] b_s;
  logic        lt_signed_s;
  logic        lt_unsigned_s;

  // Normalise operands to 64 bits and precompute both compares.
  always_comb begin
    a_s           = is_word ? sext32(a[31:0]) : a;
    b_s           = is_word ? sext32(b[31:0]) : b;
    lt_signed_s   = $signed(a_s) < $signed(b_s);
    lt_unsigned_s = a_s < b_s;
  end

  // Operation select; unknown ops leave memory unchanged.
  always_comb begin
    result = a_s;
    case (op)
      AMO_SWAP: result = b_s;
      AMO_ADD:  result = a_s + b_s;
      AMO_AND:  result = a_s & b_s;
      AMO_OR:   result = a_s | b_s;
      AMO_XOR:  result = a_s ^ b_s;
      AMO_MAX:  result = lt_signed_s   ? b_s : a_s;
      AMO_MAXU: result = lt_unsigned_s ? b_s : a_s;
      AMO_MIN:  result = lt_signed_s   ? a_s : b_s;
      AMO_MINU: result = lt_unsigned_s ? a_s : b_s;
      default:  result = a_s;
    endcase
  end

endmodule

// File: rtl/amo_executor.sv
// Cache-side AMO responder: runs one read-modify-write at a time on a 64-bit
// memory port, owns the single LR/SC reservation and returns the old value.
module amo_executor
  import amo_executor_pkg::*;
#(
  parameter int unsigned PLEN      = 56,
  parameter int unsigned RESV_GRAN = 3
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  amo_req_t        amo_req_i,
  output amo_resp_t       amo_resp_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic            mem_we_o,
  output logic [PLEN-1:0] mem_addr_o,
  output logic [63:0]     mem_wdata_o,
  output logic [7:0]      mem_be_o,
  input  logic            mem_rvalid_i,
  input  logic [63:0]     mem_rdata_i,
  input  logic            snoop_valid_i,
  input  logic [PLEN-1:0] snoop_addr_i
);

  amo_exec_state_e state_r, state_s;

  amo_t                     op_r;
  logic                     word_r;
  logic [PLEN-1:0]          addr_r;
  logic [63:0]              data_r;
  logic                     mem_req_r;
  logic                     mem_we_r;
  logic [PLEN-1:0]          mem_addr_r;
  logic [63:0]              mem_wdata_r;
  logic [7:0]               mem_be_r;
  amo_resp_t                resp_r;
  logic                     resv_valid_r;
  logic [PLEN-1:RESV_GRAN]  resv_addr_r;

  logic            req_word_s;
  logic [PLEN-1:0] req_addr_s;
  logic            snoop_resv_s;
  logic            snoop_lr_s;
  logic            sc_hit_s;
  logic            sc_sample_s;
  logic            lr_done_s;
  logic [63:0]     rd_sel_s;
  logic [63:0]     old_s;
  logic [63:0]     alu_out_s;
  logic            unused_bits;

  assign req_word_s  = (amo_req_i.size == SIZE_W);
  assign req_addr_s  = amo_req_i.operand_a[PLEN-1:0];
  assign unused_bits = ^(amo_req_i.operand_a >> PLEN) ^ ^amo_req_i.operand_a[1:0]
                     ^ ^snoop_addr_i[RESV_GRAN-1:0] ^ ^addr_r[1:0];

  // A snoop in the same cycle as the SC sample beats the reservation.
  assign snoop_resv_s = snoop_valid_i && (snoop_addr_i[PLEN-1:RESV_GRAN] == resv_addr_r);
  assign snoop_lr_s   = snoop_valid_i && (snoop_addr_i[PLEN-1:RESV_GRAN] == addr_r[PLEN-1:RESV_GRAN]);
  assign sc_hit_s     = resv_valid_r && !snoop_resv_s
                     && (req_addr_s[PLEN-1:RESV_GRAN] == resv_addr_r);
  assign sc_sample_s  = (state_r == ST_IDLE) && amo_req_i.req && (amo_req_i.amo_op == AMO_SC);
  assign lr_done_s    = (state_r == ST_RD_WAIT) && mem_rvalid_i && (op_r == AMO_LR);

  assign rd_sel_s = (word_r && addr_r[2]) ? {32'h0000_0000, mem_rdata_i[63:32]} : mem_rdata_i;
  assign old_s    = word_r ? sext32(rd_sel_s[31:0]) : rd_sel_s;

  amo_alu u_alu (
    .op      (op_r),
    .is_word (word_r),
    .a       (rd_sel_s),
    .b       (data_r),
    .result  (alu_out_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (amo_req_i.req) begin
          case (amo_req_i.amo_op)
            AMO_NONE: state_s = ST_RESP;
            AMO_SC:   state_s = sc_hit_s ? ST_WR_REQ : ST_RESP;
            default:  state_s = ST_RD_REQ;
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_REQ:  state_s = mem_gnt_i ? ST_RD_WAIT : ST_RD_REQ;
      ST_RD_WAIT: begin
        if (mem_rvalid_i) begin
          state_s = (op_r == AMO_LR) ? ST_RESP : ST_WR_REQ;
        end else begin
          state_s = ST_RD_WAIT;
        end
      end
      ST_WR_REQ:  state_s = mem_gnt_i ? ST_RESP : ST_WR_REQ;
      ST_RESP:    state_s = ST_IDLE;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Operand latch, registered memory port and response; port fields only move outside a pending request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_r        <= AMO_NONE;
      word_r      <= 1'b0;
      addr_r      <= '0;
      data_r      <= '0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_be_r    <= '0;
      resp_r      <= '0;
    end else begin
      mem_req_r  <= (state_s == ST_RD_REQ) || (state_s == ST_WR_REQ);
      resp_r.ack <= (state_s == ST_RESP);
      case (state_r)
        ST_IDLE: begin
          if (amo_req_i.req) begin
            op_r          <= amo_req_i.amo_op;
            word_r        <= req_word_s;
            addr_r        <= req_addr_s;
            data_r        <= amo_req_i.operand_b;
            mem_addr_r    <= {req_addr_s[PLEN-1:3], 3'b000};
            mem_be_r      <= lane_be(req_word_s, req_addr_s[2]);
            mem_we_r      <= (amo_req_i.amo_op == AMO_SC);
            mem_wdata_r   <= lane_wdata(req_word_s, amo_req_i.operand_b);
            resp_r.result <= ((amo_req_i.amo_op == AMO_SC) && !sc_hit_s) ? AMO_SC_FAIL : 64'd0;
          end
        end
        ST_RD_WAIT: begin
          if (mem_rvalid_i) begin
            resp_r.result <= old_s;
            if (op_r != AMO_LR) begin
              mem_we_r    <= 1'b1;
              mem_wdata_r <= lane_wdata(word_r, alu_out_s);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Reservation: LR sets it (unless snooped that cycle); any SC or matching snoop clears it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resv_valid_r <= 1'b0;
      resv_addr_r  <= '0;
    end else if (lr_done_s) begin
      resv_valid_r <= !snoop_lr_s;
      resv_addr_r  <= addr_r[PLEN-1:RESV_GRAN];
    end else if (sc_sample_s || snoop_resv_s) begin
      resv_valid_r <= 1'b0;
    end
  end

  assign amo_resp_o  = resp_r;
  assign mem_req_o   = mem_req_r;
  assign mem_we_o    = mem_we_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_wdata_o = mem_wdata_r;
  assign mem_be_o    = mem_be_r;

endmodule

// File: tb/tb_amo_executor.sv
// Scoreboard bench for amo_executor: a reference model of memory and the
// reservation predicts each response; a monitor checks it when ack appears.
module tb_amo_executor;
  import amo_executor_pkg::*;

  localparam int PLEN = 56;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  amo_req_t        req;
  amo_resp_t       resp;
  logic            mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [PLEN-1:0] mem_addr;
  logic [63:0]     mem_wdata, mem_rdata;
  logic [7:0]      mem_be;
  logic            snoop_valid;
  logic [PLEN-1:0] snoop_addr;

  always #5 clk = ~clk;

  amo_executor #(.PLEN(PLEN), .RESV_GRAN(3)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .amo_req_i(req), .amo_resp_o(resp),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .snoop_valid_i(snoop_valid), .snoop_addr_i(snoop_addr)
  );

  typedef struct {
    logic [63:0]     res;
    longint unsigned idx;
    logic [63:0]     memval;
    int              acc;
  } exp_t;

  int total = 0, bad = 0;
  logic [63:0] mem     [longint unsigned];
  logic [63:0] ref_mem [longint unsigned];
  bit              resv_v = 1'b0;
  longint unsigned resv_idx = 0;
  exp_t sb[$];
  int gnt_cnt = 0, last_cnt = 0;
  int gnt_lat = 0, rv_lat = 0;
  bit hold_wr = 1'b0;

  function automatic logic [63:0] bench_rd(input longint unsigned idx);
    return mem.exists(idx) ? mem[idx] : 64'd0;
  endfunction

  function automatic logic [63:0] ref_rd(input longint unsigned idx);
    return ref_mem.exists(idx) ? ref_mem[idx] : 64'd0;
  endfunction

  function automatic logic [63:0] sx(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_mem(input logic [63:0] addr, input logic [63:0] v);
    mem[addr >> 3]     = v;
    ref_mem[addr >> 3] = v;
  endtask

  // Reference: architectural effect of one AMO on memory and reservation.
  task automatic model(input amo_t op, input logic [1:0] size, input logic [63:0] addr,
                       input logic [63:0] b, input bit snoop_same, output exp_t e);
    longint unsigned idx = addr >> 3;
    bit w = (size == 2'b10);
    bit hi = addr[2];
    logic [63:0] word64 = ref_rd(idx);
    logic [63:0] old, bo, nv;
    bit store = 1'b0;
    old = w ? sx(hi ? word64[63:32] : word64[31:0]) : word64;
    bo  = w ? sx(b[31:0]) : b;
    nv  = old;
    if (snoop_same && resv_v && resv_idx == idx) resv_v = 1'b0;
    e.idx = idx;
    case (op)
      AMO_NONE: begin e.res = 64'd0; e.acc = 0; end
      AMO_LR:   begin e.res = old; e.acc = 1; resv_v = 1'b1; resv_idx = idx; end
      AMO_SC: begin
        if (resv_v && resv_idx == idx) begin
          nv = bo; store = 1'b1; e.res = 64'd0; e.acc = 1;
        end else begin
          e.res = 64'd1; e.acc = 0;
        end
        resv_v = 1'b0;
      end
      default: begin
        case (op)
          AMO_SWAP: nv = bo;
          AMO_ADD:  nv = old + bo;
          AMO_AND:  nv = old & bo;
          AMO_OR:   nv = old | bo;
          AMO_XOR:  nv = old ^ bo;
          AMO_MAX:  nv = ($signed(old) > $signed(bo)) ? old : bo;
          AMO_MAXU: nv = (old > bo) ? old : bo;
          AMO_MIN:  nv = ($signed(old) < $signed(bo)) ? old : bo;
          AMO_MINU: nv = (old < bo) ? old : bo;
          default:  nv = old;
        endcase
        store = 1'b1; e.res = old; e.acc = 2;
      end
    endcase
    if (store) begin
      if (!w)      word64 = nv;
      else if (hi) word64[63:32] = nv[31:0];
      else         word64[31:0] = nv[31:0];
      ref_mem[idx] = word64;
    end
    e.memval = ref_rd(idx);
  endtask

  task automatic do_amo(input amo_t op, input logic [1:0] size, input logic [63:0] addr,
                        input logic [63:0] b, input bit snoop_same, output int lat);
    exp_t e;
    model(op, size, addr, b, snoop_same, e);
    sb.push_back(e);
    req.req = 1'b1; req.amo_op = op; req.size = size; req.operand_a = addr; req.operand_b = b;
    if (snoop_same) begin
      snoop_valid = 1'b1;
      snoop_addr  = addr[PLEN-1:0];
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      snoop_valid = 1'b0;
    end while (!resp.ack && lat < 100);
    if (!resp.ack) begin
      total++; bad++;
      $display("FAIL ack_timeout: no ack after %0d cycles for op %0d", lat, op);
      void'(sb.pop_front());
    end
    req.req = 1'b0;
    @(negedge clk);
  endtask

  task automatic snoop(input logic [63:0] addr);
    snoop_valid = 1'b1;
    snoop_addr  = addr[PLEN-1:0];
    if (resv_v && resv_idx == (addr >> 3)) resv_v = 1'b0;
    @(negedge clk);
    snoop_valid = 1'b0;
  endtask

  // Memory responder with configurable grant/read latency and a hold-stability check.
  initial begin
    bit pend, in_req, prev_wait;
    int gw, rw;
    longint unsigned ridx;
    logic [PLEN-1:0] s_addr;
    logic s_we;
    logic [7:0] s_be;
    logic [63:0] s_wd, w;
    pend = 1'b0; in_req = 1'b0; prev_wait = 1'b0; gw = 0; rw = 0; ridx = 0;
    s_addr = '0; s_we = 1'b0; s_be = '0; s_wd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!rst_ni) begin
        pend = 1'b0; in_req = 1'b0; prev_wait = 1'b0;
      end else begin
        if (pend) begin
          if (rw == 0) begin
            mem_rvalid = 1'b1; mem_rdata = bench_rd(ridx); pend = 1'b0;
          end else rw--;
        end
        if (mem_req) begin
          if (prev_wait) begin
            total++;
            if ({mem_addr, mem_we, mem_be, mem_wdata} !== {s_addr, s_we, s_be, s_wd}) begin
              bad++;
              $display("FAIL port_stable: got addr=%h we=%b be=%h wd=%h held addr=%h we=%b be=%h wd=%h",
                       mem_addr, mem_we, mem_be, mem_wdata, s_addr, s_we, s_be, s_wd);
            end
          end
          if (!in_req) begin
            in_req = 1'b1;
            gw = (gnt_lat < 0) ? int'($urandom_range(0, 3)) : gnt_lat;
          end
          if (gw == 0 && !(hold_wr && mem_we)) begin
            mem_gnt = 1'b1; gnt_cnt++; in_req = 1'b0; prev_wait = 1'b0;
            if (mem_we) begin
              w = bench_rd(64'(mem_addr) >> 3);
              for (int i = 0; i < 8; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
              mem[64'(mem_addr) >> 3] = w;
            end else begin
              pend = 1'b1; ridx = 64'(mem_addr) >> 3;
              rw = (rv_lat < 0) ? int'($urandom_range(0, 3)) : rv_lat;
            end
          end else begin
            if (gw > 0) gw--;
            prev_wait = 1'b1;
            s_addr = mem_addr; s_we = mem_we; s_be = mem_be; s_wd = mem_wdata;
          end
        end else begin
          prev_wait = 1'b0; in_req = 1'b0;
        end
      end
    end
  end

  // Monitor: every ack pops one expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && resp.ack) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got result %h with nothing outstanding", resp.result);
        end else begin
          e = sb.pop_front();
          check("result", resp.result, e.res);
          check("mem_word", bench_rd(e.idx), e.memval);
          check("mem_accesses", 64'(gnt_cnt - last_cnt), 64'(e.acc));
          last_cnt = gnt_cnt;
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
    check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 64'd0);
    check({tag, "_mem_be"}, 64'(mem_be), 64'd0);
    check({tag, "_resp"}, {63'd0, resp.ack} | resp.result, 64'd0);
  endtask

  initial begin
    int lat, n;
    amo_t op;
    logic [1:0] sz;
    logic [63:0] a;
    req = '0; snoop_valid = 1'b0; snoop_addr = '0;
    for (int k = 0; k < 4; k++) set_mem(64'h2000 + 64'(8 * k), {$urandom, $urandom});
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    rst_ni = 1'b1;
    @(negedge clk);

    set_mem(64'h8000_1000, 64'h5);
    do_amo(AMO_ADD, 2'b11, 64'h8000_1000, 64'h3, 1'b0, lat);
    check("add_d_latency", 64'(lat), 64'd4);

    set_mem(64'h8000_1000, 64'hFFFF_FFFE_0000_0000);
    do_amo(AMO_MAX, 2'b10, 64'h8000_1004, 64'h1, 1'b0, lat);
    set_mem(64'h8000_1000, 64'hFFFF_FFFE_0000_0000);
    do_amo(AMO_MINU, 2'b10, 64'h8000_1004, 64'h1, 1'b0, lat);
    set_mem(64'h8000_1000, 64'hFFFF_FFFE_0000_0000);
    do_amo(AMO_MAXU, 2'b10, 64'h8000_1004, 64'h1, 1'b0, lat);

    set_mem(64'h2000, 64'h11);
    do_amo(AMO_LR, 2'b11, 64'h2000, 64'h0, 1'b0, lat);
    do_amo(AMO_SC, 2'b11, 64'h2000, 64'hAA, 1'b0, lat);
    check("sc_hit_latency", 64'(lat), 64'd2);
    do_amo(AMO_SC, 2'b11, 64'h2000, 64'hBB, 1'b0, lat);
    check("sc_miss_latency", 64'(lat), 64'd1);

    do_amo(AMO_LR, 2'b11, 64'h2000, 64'h0, 1'b0, lat);
    snoop(64'h2004);
    do_amo(AMO_SC, 2'b11, 64'h2000, 64'hCC, 1'b0, lat);
    do_amo(AMO_LR, 2'b11, 64'h2000, 64'h0, 1'b0, lat);
    do_amo(AMO_SC, 2'b11, 64'h2000, 64'hDD, 1'b1, lat);
    do_amo(AMO_NONE, 2'b11, 64'h2000, 64'h1, 1'b0, lat);
    check("none_latency", 64'(lat), 64'd1);

    gnt_lat = 5; rv_lat = 3;
    do_amo(AMO_XOR, 2'b11, 64'h2008, 64'hF0F0_0000_1234_5678, 1'b0, lat);
    check("slow_mem_latency", 64'(lat), 64'd17);
    gnt_lat = 0; rv_lat = 0;

    // Reset while the write is being held off.
    do_amo(AMO_LR, 2'b11, 64'h2000, 64'h0, 1'b0, lat);
    hold_wr = 1'b1;
    req.req = 1'b1; req.amo_op = AMO_ADD; req.size = 2'b11; req.operand_a = 64'h2000; req.operand_b = 64'h1;
    n = 0;
    while (!(mem_req && mem_we) && n < 50) begin @(negedge clk); n++; end
    check("reached_wr_req", 64'(mem_req && mem_we), 64'd1);
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("midreset");
    resv_v = 1'b0;
    req.req = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1; hold_wr = 1'b0; last_cnt = gnt_cnt;
    @(negedge clk);
    do_amo(AMO_SC, 2'b11, 64'h2000, 64'h77, 1'b0, lat);

    gnt_lat = -1; rv_lat = -1;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 3) == 0) op = ($urandom_range(0, 1) == 0) ? AMO_LR : AMO_SC;
      else op = amo_t'(4'($urandom_range(0, 11)));
      sz = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
      a  = 64'h2000 + 64'(8 * $urandom_range(0, 3)) + ((sz == 2'b10) ? 64'(4 * $urandom_range(0, 1)) : 64'd0);
      if ($urandom_range(0, 7) == 0) snoop(64'h2000 + 64'($urandom_range(0, 31)));
      do_amo(op, sz, a, {$urandom, $urandom}, ($urandom_range(0, 15) == 0), lat);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
